aes_key_sched: RTL and testbench
================================

AES_KEY_SCHED -- requirements
Module: aes_key_sched

Interface
REQ-001 Parameter: NR, default 10, number of expansion rounds (AES-128); storage holds NR+1 round keys.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  asynchronous, active-high reset.
REQ-004 start  input  1  request key expansion; sampled only in IDLE.
REQ-005 inv  input  1  read order select; captured with start (1 = decryption order).
REQ-006 key_in  input  128  cipher key; byte i at bits [8i+7:8i]; word w at bits [32w+31:32w].
REQ-007 ark_o  output  1  ARK-mode select to the AES vector datapath.
REQ-008 rcon_o  output  32  round-constant word to the datapath: {24'b0, rcon}.
REQ-009 vb_o  output  128  current round key to the datapath.
REQ-010 vc_i  input  128  next round key returned combinationally by the datapath in ARK mode.
REQ-011 busy  output  1  high while in EXPAND.
REQ-012 done  output  1  one-cycle completion pulse.
REQ-013 keys_valid  output  1  buffer holds a complete schedule.
REQ-014 rd_idx  input  4  round-key read index.
REQ-015 rd_key  output  128  round key selected by rd_idx, combinational from storage.

Function
REQ-016 FSM states SHALL be IDLE, EXPAND and DONE only; unused encodings return to IDLE.
REQ-017 IDLE with start=1 at an edge SHALL: key[0]<=key_in; cur<=key_in; inv_q<=inv; round<=1; rcon<=8'h01; keys_valid<=0; go to EXPAND.
REQ-018 In EXPAND: ark_o=1, vb_o=cur, rcon_o={24'b0,rcon}; elsewhere ark_o=0, vb_o=0, rcon_o=0.
REQ-019 Each EXPAND edge SHALL: key[round]<=vc_i; cur<=vc_i; round<=round+1; rcon<=xtime(rcon) (shift left 1, XOR 8'h1b if bit7 was set).
REQ-020 Rcon sequence for rounds 1..10 SHALL be 01,02,04,08,10,20,40,80,1b,36.
REQ-021 The EXPAND edge with round==NR SHALL go to DONE.
REQ-022 DONE SHALL assert done=1 for exactly one cycle, set keys_valid<=1, and return to IDLE on the next edge.
REQ-023 Latency: counting the start-sampling edge as edge 0, key[NR] is written at edge NR, and done is high between edges NR and NR+1 (11 cycles for NR=10).
REQ-024 busy SHALL equal (state==EXPAND).
REQ-025 start while in EXPAND or DONE SHALL be ignored, with no restart and no queuing.
REQ-026 rd_key SHALL be key[rd_idx] if inv_q=0 and key[NR-rd_idx] if inv_q=1, for rd_idx<=NR.
REQ-027 rd_key SHALL be 128'b0 for rd_idx>NR.
REQ-028 rd_key is not gated by keys_valid; a read during EXPAND returns the stored contents, partial or stale.
REQ-029 A start accepted while keys_valid=1 SHALL clear keys_valid on that edge; old keys are overwritten progressively.
REQ-030 Storage SHALL be NR+1 x 128-bit registers, written only per REQ-017 and REQ-019.

Reset
REQ-031 While rst=1: state=IDLE, round=0, rcon=8'h01, cur=0, inv_q=0, all key[] =0, busy=0, done=0, keys_valid=0, ark_o=0, rcon_o=0, vb_o=0.
REQ-032 rst asserted mid-EXPAND SHALL abort immediately with all state cleared per REQ-031; after release, a new start is required and no done pulse is issued.
REQ-033 The first start SHALL be accepted at the first clk edge after rst deasserts.

Verification
REQ-034 The bench SHALL connect ark_o/rcon_o/vb_o/vc_i to the team's AES vector unit in ARK mode (ss=ssm=0) for all scenarios.
REQ-035 FIPS-197 key 2b7e151628aed2a6abf7158809cf4f3c, inv=0 -> done exactly 11 cycles after start. rd_idx=1 gives a0fafe1788542cb123a339392a6c7605 (FIPS byte order). rd_idx=10 gives d014f9a8c9ee2589e13f0cc8b6630ca6.
REQ-036 Same key with inv=1 -> rd_idx=0 gives d014f9a8c9ee2589e13f0cc8b6630ca6, and rd_idx=10 gives 2b7e151628aed2a6abf7158809cf4f3c.
REQ-037 Monitor rcon_o during EXPAND -> low byte equals 01,02,04,08,10,20,40,80,1b,36 on consecutive cycles; busy high for exactly 10 cycles.
REQ-038 Pulse start again at the 4th EXPAND cycle -> no effect; done still occurs 11 cycles after the original start.
REQ-039 Assert rst at the 5th EXPAND cycle -> all outputs zero and keys_valid=0 immediately; no done pulse. Restart with key 000102030405060708090a0b0c0d0e0f -> rd_idx=10 gives 13111d7fe3944a17f307a78b4d2b30c5.
REQ-040 Read rd_idx=11..15 after completion -> rd_key=0; a second start after completion drops keys_valid on the start edge and raises it again with the new done.

Source files
------------

// File: rtl/aes_key_sched.sv
// AES-128 key schedule controller. It drives the vector datapath in ARK mode
// (current round key plus round constant out, next round key back on vc_i),
// stores all NR+1 round keys, and serves them in forward or inverse order.
module aes_key_sched #(
  parameter int unsigned NR = 10
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic         inv,
  input  logic [127:0] key_in,
  output logic         ark_o,
  output logic [31:0]  rcon_o,
  output logic [127:0] vb_o,
  input  logic [127:0] vc_i,
  output logic         busy,
  output logic         done,
  output logic         keys_valid,
  input  logic [3:0]   rd_idx,
  output logic [127:0] rd_key
);

  localparam logic [3:0] NrIdx = 4'(NR);

  typedef enum logic [1:0] {
    StIdle   = 2'd0,
    StExpand = 2'd1,
    StDone   = 2'd2
  } state_e;

  state_e       state_q, state_d;
  logic [3:0]   round_q, round_d;
  logic [7:0]   rcon_q, rcon_d;
  logic [127:0] cur_q, cur_d;
  logic         inv_q, inv_d;
  logic         busy_q, busy_d;
  logic         done_q, done_d;
  logic         valid_q, valid_d;
  logic [127:0] key_q [0:NR];
  logic [127:0] key_d [0:NR];

  // Next-state: start capture in idle, one round key per cycle in expand.
  always_comb begin
    state_d = state_q;
    round_d = round_q;
    rcon_d  = rcon_q;
    cur_d   = cur_q;
    inv_d   = inv_q;
    valid_d = valid_q;
    key_d   = key_q;
    busy_d  = 1'b0;
    done_d  = 1'b0;
    case (state_q)
      StIdle: begin
        if (start) begin
          key_d[0] = key_in;
          cur_d    = key_in;
          inv_d    = inv;
          round_d  = 4'd1;
          rcon_d   = 8'h01;
          valid_d  = 1'b0;
          busy_d   = 1'b1;
          state_d  = StExpand;
        end
      end
      StExpand: begin
        if (round_q <= NrIdx) begin
          key_d[round_q] = vc_i;
        end
        cur_d   = vc_i;
        round_d = round_q + 4'd1;
        // xtime in GF(2^8)
        rcon_d  = {rcon_q[6:0], 1'b0} ^ (rcon_q[7] ? 8'h1b : 8'h00);
        if (round_q == NrIdx) begin
          done_d  = 1'b1;
          state_d = StDone;
        end else begin
          busy_d = 1'b1;
        end
      end
      StDone: begin
        valid_d = 1'b1;
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // State and storage registers, cleared asynchronously.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      round_q <= 4'd0;
      rcon_q  <= 8'h01;
      cur_q   <= '0;
      inv_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      valid_q <= 1'b0;
      key_q   <= '{default: '0};
    end else begin
      state_q <= state_d;
      round_q <= round_d;
      rcon_q  <= rcon_d;
      cur_q   <= cur_d;
      inv_q   <= inv_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      valid_q <= valid_d;
      key_q   <= key_d;
    end
  end

  // Datapath operands are only presented while expanding; zero otherwise.
  always_comb begin
    ark_o  = busy_q;
    vb_o   = busy_q ? cur_q : '0;
    rcon_o = busy_q ? {24'b0, rcon_q} : '0;
  end

  assign busy       = busy_q;
  assign done       = done_q;
  assign keys_valid = valid_q;

  // Read port is ungated: partial or stale contents are visible mid-expansion.
  always_comb begin
    rd_key = '0;
    if (rd_idx <= NrIdx) begin
      rd_key = inv_q ? key_q[NrIdx - rd_idx] : key_q[rd_idx];
    end
  end

endmodule

// File: tb/tb_aes_key_sched.sv
// Bench for aes_key_sched: models the ARK datapath, keeps a schedule-level
// reference model, and compares every output every cycle plus FIPS-197 vectors.
module tb_aes_key_sched;

  localparam int unsigned NR = 10;

  logic         clk = 1'b0;
  logic         rst, start, inv;
  logic [127:0] key_in, vc_i, vb_o, rd_key;
  logic         ark_o, busy, done, keys_valid;
  logic [31:0]  rcon_o;
  logic [3:0]   rd_idx;

  int checks = 0;
  int errors = 0;
  logic chk_en = 1'b0;

  logic [7:0] sbox [0:255];
  logic [7:0] rcon_tab [1:10];

  aes_key_sched #(.NR(NR)) dut (
    .clk(clk), .rst(rst), .start(start), .inv(inv), .key_in(key_in),
    .ark_o(ark_o), .rcon_o(rcon_o), .vb_o(vb_o), .vc_i(vc_i),
    .busy(busy), .done(done), .keys_valid(keys_valid),
    .rd_idx(rd_idx), .rd_key(rd_key)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h t=%0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [7:0] gmul(input logic [7:0] a_in, input logic [7:0] b_in);
    logic [7:0] a, b, p;
    a = a_in; b = b_in; p = 8'h00;
    for (int i = 0; i < 8; i++) begin
      if (b[0]) p = p ^ a;
      a = {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
      b = b >> 1;
    end
    return p;
  endfunction

  function automatic logic [31:0] sub_word(input logic [31:0] w);
    return {sbox[w[31:24]], sbox[w[23:16]], sbox[w[15:8]], sbox[w[7:0]]};
  endfunction

  // Byte 0 sits in the low bits, so RotWord moves the low byte to the top.
  function automatic logic [31:0] rot_word(input logic [31:0] w);
    return {w[7:0], w[31:8]};
  endfunction

  // FIPS hex strings list byte 0 first; the bus keeps byte 0 in bits [7:0].
  function automatic logic [127:0] bswap(input logic [127:0] x);
    logic [127:0] y;
    for (int i = 0; i < 16; i++) y[8*i +: 8] = x[8*(15-i) +: 8];
    return y;
  endfunction

  // Reference schedule: textbook word recurrence over all 4*(NR+1) words.
  function automatic logic [NR:0][127:0] expand_key(input logic [127:0] k);
    logic [31:0] w [0:4*NR+3];
    logic [31:0] t;
    logic [NR:0][127:0] s;
    for (int i = 0; i < 4; i++) w[i] = k[32*i +: 32];
    for (int i = 4; i < 4 * (NR + 1); i++) begin
      t = w[i-1];
      if (i % 4 == 0) t = sub_word(rot_word(t)) ^ {24'b0, rcon_tab[i/4]};
      w[i] = w[i-4] ^ t;
    end
    for (int r = 0; r <= NR; r++) s[r] = {w[4*r+3], w[4*r+2], w[4*r+1], w[4*r]};
    return s;
  endfunction

  // Vector unit in ARK mode: next round key from current key and rcon word.
  function automatic logic [127:0] ark_step(input logic [127:0] vb, input logic [31:0] rc);
    logic [31:0] t, n0, n1, n2, n3;
    t  = sub_word(rot_word(vb[127:96])) ^ rc;
    n0 = vb[31:0] ^ t;
    n1 = vb[63:32] ^ n0;
    n2 = vb[95:64] ^ n1;
    n3 = vb[127:96] ^ n2;
    return {n3, n2, n1, n0};
  endfunction

  always @* vc_i = ark_step(vb_o, rcon_o);

  // Reference model: m_cnt is 0 idle, 1..NR expanding round m_cnt, NR+1 done.
  int                 m_cnt;
  logic               m_valid, m_inv;
  logic [NR:0][127:0] m_store, m_sched;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_cnt   <= 0;
      m_valid <= 1'b0;
      m_inv   <= 1'b0;
      m_store <= '0;
      m_sched <= '0;
    end else if (m_cnt == 0) begin
      if (start) begin
        m_sched    <= expand_key(key_in);
        m_store[0] <= key_in;
        m_inv      <= inv;
        m_valid    <= 1'b0;
        m_cnt      <= 1;
      end
    end else if (m_cnt <= NR) begin
      m_store[m_cnt] <= m_sched[m_cnt];
      m_cnt          <= m_cnt + 1;
    end else begin
      m_valid <= 1'b1;
      m_cnt   <= 0;
    end
  end

  // Per-cycle compare of every output against the model.
  always @(negedge clk) begin
    if (chk_en) begin
      automatic logic         e_busy = (m_cnt >= 1 && m_cnt <= NR);
      automatic logic [127:0] e_rd = '0;
      automatic int           ri = int'(rd_idx);
      if (ri <= NR) e_rd = m_inv ? m_store[NR - ri] : m_store[ri];
      chk("busy", 128'(busy), 128'(e_busy));
      chk("ark_o", 128'(ark_o), 128'(e_busy));
      chk("done", 128'(done), 128'(m_cnt == NR + 1));
      chk("keys_valid", 128'(keys_valid), 128'(m_valid));
      chk("vb_o", vb_o, e_busy ? m_sched[m_cnt-1] : 128'b0);
      chk("rcon_o", 128'(rcon_o), e_busy ? 128'(rcon_tab[m_cnt]) : 128'b0);
      chk("rd_key", rd_key, e_rd);
    end
  end

  logic [7:0] rcon_seen [$];
  int         busy_n;

  task automatic go(input logic [127:0] k, input logic iv);
    key_in = k;
    inv    = iv;
    start  = 1'b1;
    @(posedge clk);
    #2 start = 1'b0;
  endtask

  // Returns the sample index (1 = cycle after the start edge) at which done
  // appeared, or 0 if it never did within the bound or rst was injected.
  task automatic wait_done(input int restart_at, input int rst_at, output int found);
    found  = 0;
    busy_n = 0;
    rcon_seen.delete();
    for (int n = 1; n <= 40; n++) begin
      @(negedge clk);
      if (busy) begin
        busy_n++;
        rcon_seen.push_back(rcon_o[7:0]);
      end
      if (n == restart_at) start = 1'b1;
      if (n == restart_at + 1) start = 1'b0;
      if (n == rst_at) begin
        #2 rst = 1'b1;
        #1;
        chk("rst_busy", 128'(busy), 128'b0);
        chk("rst_done", 128'(done), 128'b0);
        chk("rst_valid", 128'(keys_valid), 128'b0);
        chk("rst_ark", 128'(ark_o), 128'b0);
        chk("rst_rcon", 128'(rcon_o), 128'b0);
        chk("rst_vb", vb_o, 128'b0);
        chk("rst_rdkey", rd_key, 128'b0);
        return;
      end
      if (done) begin
        found = n;
        return;
      end
    end
  endtask

  localparam logic [127:0] FipsKey = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] FipsR1  = 128'ha0fafe1788542cb123a339392a6c7605;
  localparam logic [127:0] FipsR10 = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
  localparam logic [127:0] SeqKey  = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] SeqR10  = 128'h13111d7fe3944a17f307a78b4d2b30c5;

  initial begin
    int found;
    int done_n;
    logic [7:0] b, s, c;
    logic [7:0] exp_rcon [0:9];
    logic [NR:0][127:0] pin;

    rst = 1'b1; start = 1'b0; inv = 1'b0; key_in = '0; rd_idx = 4'd0;
    exp_rcon = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h1b, 8'h36};
    rcon_tab = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h1b, 8'h36};

    // S-box from the GF(2^8) inverse and the affine map.
    c = 8'h63;
    for (int x = 0; x < 256; x++) begin
      b = 8'h00;
      for (int y = 1; y < 256; y++) if (gmul(8'(x), 8'(y)) == 8'h01) b = 8'(y);
      for (int i = 0; i < 8; i++)
        s[i] = b[i] ^ b[(i+4)%8] ^ b[(i+5)%8] ^ b[(i+6)%8] ^ b[(i+7)%8] ^ c[i];
      sbox[x] = s;
    end

    // Pin the model with hand-known values.
    chk("sbox_00", 128'(sbox[8'h00]), 128'h63);
    chk("sbox_01", 128'(sbox[8'h01]), 128'h7c);
    chk("sbox_53", 128'(sbox[8'h53]), 128'hed);
    chk("sbox_ff", 128'(sbox[8'hff]), 128'h16);
    pin = expand_key(bswap(FipsKey));
    chk("model_fips_r1", pin[1], bswap(FipsR1));
    chk("model_fips_r10", pin[10], bswap(FipsR10));
    pin = expand_key(bswap(SeqKey));
    chk("model_seq_r10", pin[10], bswap(SeqR10));

    // Reset state.
    #12;
    chk_en = 1'b1;
    chk("reset_busy", 128'(busy), 128'b0);
    chk("reset_done", 128'(done), 128'b0);
    chk("reset_valid", 128'(keys_valid), 128'b0);
    chk("reset_vb", vb_o, 128'b0);
    chk("reset_rcon", 128'(rcon_o), 128'b0);
    chk("reset_rdkey", rd_key, 128'b0);
    @(negedge clk);
    rst = 1'b0;

    // Forward expansion of the FIPS key: latency, busy length, rcon sequence.
    go(bswap(FipsKey), 1'b0);
    wait_done(0, 0, found);
    chk("fwd_latency", 128'(found), 128'd11);
    chk("fwd_busy_cycles", 128'(busy_n), 128'd10);
    chk("rcon_count", 128'(rcon_seen.size()), 128'd10);
    for (int i = 0; i < 10 && i < rcon_seen.size(); i++)
      chk($sformatf("rcon_%0d", i + 1), 128'(rcon_seen[i]), 128'(exp_rcon[i]));
    @(negedge clk);
    chk("fwd_valid", 128'(keys_valid), 128'd1);
    rd_idx = 4'd1;  #1 chk("fwd_rd1", rd_key, bswap(FipsR1));
    rd_idx = 4'd10; #1 chk("fwd_rd10", rd_key, bswap(FipsR10));

    // Inverse read order.
    @(negedge clk);
    go(bswap(FipsKey), 1'b1);
    wait_done(0, 0, found);
    chk("inv_latency", 128'(found), 128'd11);
    @(negedge clk);
    rd_idx = 4'd0;  #1 chk("inv_rd0", rd_key, bswap(FipsR10));
    rd_idx = 4'd10; #1 chk("inv_rd10", rd_key, bswap(FipsKey));

    // Start pulse in the 4th expand cycle must be ignored.
    @(negedge clk);
    go(bswap(FipsKey), 1'b0);
    wait_done(4, 0, found);
    chk("restart_ignored_latency", 128'(found), 128'd11);
    @(negedge clk);
    @(negedge clk);
    chk("no_queued_start", 128'(busy), 128'd0);

    // Reset in the 5th expand cycle aborts with no done pulse.
    go(bswap(FipsKey), 1'b0);
    wait_done(0, 5, found);
    done_n = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (done) done_n++;
    end
    chk("abort_no_done", 128'(done_n), 128'd0);
    rst = 1'b0;
    go(bswap(SeqKey), 1'b0);
    wait_done(0, 0, found);
    chk("seq_latency", 128'(found), 128'd11);
    @(negedge clk);
    rd_idx = 4'd10; #1 chk("seq_rd10", rd_key, bswap(SeqR10));

    // Out-of-range reads, then a second start drops and restores keys_valid.
    for (int i = 11; i <= 15; i++) begin
      rd_idx = 4'(i);
      #1 chk($sformatf("oob_rd%0d", i), rd_key, 128'b0);
    end
    rd_idx = 4'd3;
    @(negedge clk);
    chk("pre_restart_valid", 128'(keys_valid), 128'd1);
    go(bswap(FipsKey), 1'b0);
    chk("start_edge_valid", 128'(keys_valid), 128'd0);
    wait_done(0, 0, found);
    chk("second_latency", 128'(found), 128'd11);
    @(negedge clk);
    chk("second_valid", 128'(keys_valid), 128'd1);
    @(negedge clk);

    chk_en = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
